// File: rtl/if_fetch_stage_if.sv
// Bus bundle between the fetch stage, the instruction memory and the decode stage.
// stall/redirect are level controls sampled on every rising edge (no valid/ready pairing);
// id_valid qualifies the id_* payload, and imem_rd must be valid in the same cycle as imem_r.
interface if_fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_a;
  logic        imem_r;
  logic [31:0] imem_rd;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_addr_err;
  logic        id_range_err;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_rd,
    output imem_a, imem_r, pc, id_valid, id_instr, id_pc, id_pc4,
           id_addr_err, id_range_err, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rd,
    input  imem_a, imem_r, pc, id_valid, id_instr, id_pc, id_pc4,
           id_addr_err, id_range_err, fetch_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, addresses imem combinationally and registers
// the returned word into IF/ID, tagging misaligned-redirect and out-of-window fetches.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0040_0000,
  parameter int unsigned IMEM_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  fetch
);
  localparam logic [29:0] WORDS = 30'(IMEM_WORDS);

  logic [31:0] pc_q;
  logic        pend_misalign;
  logic [31:0] offset;
  logic        in_range;
  logic        aligned;

  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc4_q;
  logic        id_addr_err_q;
  logic        id_range_err_q;
  logic [31:0] fetch_count_q;

  assign offset   = pc_q - IMEM_BASE;
  assign in_range = offset[31:2] < WORDS;
  assign aligned  = (pc_q[1:0] == 2'b00);

  assign fetch.imem_a = offset;
  assign fetch.imem_r = !rst && !fetch.stall && in_range && aligned;

  assign fetch.pc           = pc_q;
  assign fetch.id_valid     = id_valid_q;
  assign fetch.id_instr     = id_instr_q;
  assign fetch.id_pc        = id_pc_q;
  assign fetch.id_pc4       = id_pc4_q;
  assign fetch.id_addr_err  = id_addr_err_q;
  assign fetch.id_range_err = id_range_err_q;
  assign fetch.fetch_count  = fetch_count_q;

  // The misalign flag rides with the PC so the redirect's low bits reach the
  // first instruction actually delivered from the new stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      pend_misalign <= 1'b0;
    end else if (fetch.redirect) begin
      pc_q          <= {fetch.redirect_pc[31:2], 2'b00};
      pend_misalign <= |fetch.redirect_pc[1:0];
    end else if (!fetch.stall) begin
      pc_q          <= pc_q + 32'd4;
      pend_misalign <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q     <= 1'b0;
      id_instr_q     <= 32'h0;
      id_pc_q        <= 32'h0;
      id_pc4_q       <= 32'h0;
      id_addr_err_q  <= 1'b0;
      id_range_err_q <= 1'b0;
      fetch_count_q  <= 32'h0;
    end else if (fetch.redirect) begin
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
    end else if (!fetch.stall) begin
      id_valid_q     <= 1'b1;
      // imem_rd is undefined outside the window, so deliver a NOP instead.
      id_instr_q     <= in_range ? fetch.imem_rd : 32'h0;
      id_pc_q        <= pc_q;
      id_pc4_q       <= pc_q + 32'd4;
      id_addr_err_q  <= pend_misalign;
      id_range_err_q <= !in_range;
      fetch_count_q  <= fetch_count_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized control traffic
// checked against a behavioural fetch model.
module tb_if_fetch_stage;
  localparam logic [31:0] BASE   = 32'h0040_0000;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] WORDS  = 32'd2048;

  logic clk = 1'b0;
  logic rst;
  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(RST_PC), .IMEM_BASE(BASE), .IMEM_WORDS(2048)) dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  // Poison value when not reading, so a fetch that uses stale data is visible.
  assign bus.imem_rd = bus.imem_r ? mem[bus.imem_a[12:2]] : 32'hDEAD_BEEF;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_cnt;
  logic        m_valid, m_aerr, m_rerr, m_pend;

  function automatic logic m_in_range();
    logic [31:0] off;
    off = m_pc - BASE;
    return (off / 4) < WORDS;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_pend = 1'b0; m_valid = 1'b0; m_instr = '0;
    m_id_pc = '0; m_id_pc4 = '0; m_aerr = 1'b0; m_rerr = 1'b0; m_cnt = '0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] rpc);
    logic [31:0] off;
    if (r) begin
      m_valid = 1'b0;
      m_instr = '0;
      m_pend  = (rpc % 4) != 0;
      m_pc    = rpc - (rpc % 4);
    end else if (!s) begin
      off      = m_pc - BASE;
      m_valid  = 1'b1;
      m_instr  = m_in_range() ? mem[off / 4] : 32'h0;
      m_rerr   = !m_in_range();
      m_id_pc  = m_pc;
      m_id_pc4 = m_pc + 4;
      m_aerr   = m_pend;
      m_pend   = 1'b0;
      m_cnt    = m_cnt + 1;
      m_pc     = m_pc + 4;
    end
  endtask

  // Clock/drive helpers
  task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    bus.stall = s; bus.redirect = r; bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(bus.stall, bus.redirect, bus.redirect_pc);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (bus.pc !== RST_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RST_PC); end
    vectors++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.id_valid); end
    vectors++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", bus.id_instr); end
    vectors++; if ({bus.id_pc, bus.id_pc4} !== 64'h0) begin errors++; $display("FAIL reset_idpc got=%h/%h exp=0/0", bus.id_pc, bus.id_pc4); end
    vectors++; if ({bus.id_addr_err, bus.id_range_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b%b exp=00", bus.id_addr_err, bus.id_range_err); end
    vectors++; if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.fetch_count); end
    vectors++; if (bus.imem_r !== 1'b0) begin errors++; $display("FAIL reset_imem_r got=%b exp=0", bus.imem_r); end
  endtask

  task automatic test_free_run();
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if ({bus.imem_r, bus.imem_a} !== {1'b1, 32'h0}) begin errors++; $display("FAIL run_imem got=%b/%h exp=1/0", bus.imem_r, bus.imem_a); end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++; if (bus.pc !== RST_PC + 4 * (i + 1)) begin errors++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, bus.pc, RST_PC + 4 * (i + 1)); end
      vectors++; if (bus.id_instr !== 32'h1000_0000 + i) begin errors++; $display("FAIL run_instr[%0d] got=%h exp=%h", i, bus.id_instr, 32'h1000_0000 + i); end
      vectors++; if ({bus.id_valid, bus.id_pc, bus.id_pc4} !== {1'b1, RST_PC + 4 * i, RST_PC + 4 * i + 4}) begin errors++; $display("FAIL run_idpc[%0d] got=%b/%h/%h exp=1/%h", i, bus.id_valid, bus.id_pc, bus.id_pc4, RST_PC + 4 * i); end
    end
    vectors++; if (bus.fetch_count !== 32'd8) begin errors++; $display("FAIL run_count got=%0d exp=8", bus.fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      vectors++; if (bus.imem_r !== 1'b0) begin errors++; $display("FAIL stall_imem_r[%0d] got=%b exp=0", k, bus.imem_r); end
      tick();
      vectors++; if ({bus.pc, bus.id_pc, bus.id_instr} !== {32'h0040_0008, 32'h0040_0004, 32'h1000_0001}) begin errors++; $display("FAIL stall_hold[%0d] got=%h/%h/%h exp=00400008/00400004/10000001", k, bus.pc, bus.id_pc, bus.id_instr); end
      vectors++; if (bus.fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d] got=%0d exp=2", k, bus.fetch_count); end
    end
    drive(1'b0, 1'b0, 32'h0);
    vectors++; if (bus.imem_r !== 1'b1) begin errors++; $display("FAIL resume_imem_r got=%b exp=1", bus.imem_r); end
    tick();
    vectors++; if ({bus.pc, bus.id_pc, bus.id_instr, bus.fetch_count} !== {32'h0040_000C, 32'h0040_0008, 32'h1000_0002, 32'd3}) begin errors++; $display("FAIL resume got=%h/%h/%h/%0d exp=0040000c/00400008/10000002/3", bus.pc, bus.id_pc, bus.id_instr, bus.fetch_count); end
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, 1'b1, 32'h0040_0040);
    tick();
    vectors++; if ({bus.id_valid, bus.id_instr, bus.pc} !== {1'b0, 32'h0, 32'h0040_0040}) begin errors++; $display("FAIL redir_squash got=%b/%h/%h exp=0/0/00400040", bus.id_valid, bus.id_instr, bus.pc); end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    vectors++; if ({bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4} !== {1'b1, mem[16], 32'h0040_0040, 32'h0040_0044}) begin errors++; $display("FAIL redir_deliver got=%b/%h/%h/%h exp=1/%h/00400040/00400044", bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4, mem[16]); end
  endtask

  task automatic test_range();
    logic [31:0] exp_cnt;
    drive(1'b0, 1'b1, 32'h0040_2000);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    vectors++; if ({bus.imem_r, bus.imem_a, bus.pc} !== {1'b0, 32'h0000_2000, 32'h0040_2000}) begin errors++; $display("FAIL range_imem got=%b/%h/%h exp=0/00002000/00402000", bus.imem_r, bus.imem_a, bus.pc); end
    exp_cnt = m_cnt + 1;
    tick();
    vectors++; if ({bus.id_valid, bus.id_instr, bus.id_range_err, bus.fetch_count} !== {1'b1, 32'h0, 1'b1, exp_cnt}) begin errors++; $display("FAIL range_deliver got=%b/%h/%b/%0d exp=1/0/1/%0d", bus.id_valid, bus.id_instr, bus.id_range_err, bus.fetch_count, exp_cnt); end
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b1, 32'h0040_0006);
    tick();
    vectors++; if ({bus.pc, bus.id_valid} !== {32'h0040_0004, 1'b0}) begin errors++; $display("FAIL mis_pc got=%h/%b exp=00400004/0", bus.pc, bus.id_valid); end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    vectors++; if ({bus.id_addr_err, bus.id_pc, bus.id_instr} !== {1'b1, 32'h0040_0004, 32'h1000_0001}) begin errors++; $display("FAIL mis_tag got=%b/%h/%h exp=1/00400004/10000001", bus.id_addr_err, bus.id_pc, bus.id_instr); end
    tick();
    vectors++; if ({bus.id_addr_err, bus.id_range_err} !== 2'b00) begin errors++; $display("FAIL mis_clear got=%b%b exp=00", bus.id_addr_err, bus.id_range_err); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 32'h0);
    tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++; if ({bus.pc, bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4} !== {RST_PC, 1'b0, 96'h0}) begin errors++; $display("FAIL async_regs got=%h/%b/%h/%h/%h exp=%h/0/0/0/0", bus.pc, bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4, RST_PC); end
    vectors++; if ({bus.id_addr_err, bus.id_range_err, bus.fetch_count, bus.imem_r} !== {2'b00, 32'h0, 1'b0}) begin errors++; $display("FAIL async_misc got=%b%b/%0d/%b exp=00/0/0", bus.id_addr_err, bus.id_range_err, bus.fetch_count, bus.imem_r); end
    @(negedge clk);
    rst = 1'b0; bus.stall = 1'b0;
    tick();
    vectors++; if ({bus.id_pc, bus.id_instr, bus.pc, bus.fetch_count} !== {RST_PC, 32'h1000_0000, RST_PC + 32'd4, 32'd1}) begin errors++; $display("FAIL async_restart got=%h/%h/%h/%0d exp=%h/10000000/%h/1", bus.id_pc, bus.id_instr, bus.pc, bus.fetch_count, RST_PC, RST_PC + 32'd4); end
  endtask

  task automatic test_random();
    logic        s, r, exp_r;
    logic [31:0] rpc;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: rpc = BASE + 4 * $urandom_range(0, 2047);
        1: rpc = BASE + 4 * $urandom_range(0, 2047) + $urandom_range(1, 3);
        2: rpc = BASE + 4 * $urandom_range(2040, 2100) + $urandom_range(0, 3);
        3: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: rpc = $urandom;
      endcase
      drive(s, r, rpc);
      exp_r = !s && m_in_range() && (m_pc % 4 == 0);
      vectors++; if ({bus.imem_r, bus.imem_a} !== {exp_r, m_pc - BASE}) begin errors++; $display("FAIL rnd_imem[%0d] got=%b/%h exp=%b/%h", n, bus.imem_r, bus.imem_a, exp_r, m_pc - BASE); end
      tick();
      vectors++; if ({bus.pc, bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4, bus.id_addr_err, bus.id_range_err, bus.fetch_count}
                     !== {m_pc, m_valid, m_instr, m_id_pc, m_id_pc4, m_aerr, m_rerr, m_cnt}) begin
        errors++;
        $display("FAIL rnd_state[%0d] got=%h %b %h %h %h %b%b %0d exp=%h %b %h %h %h %b%b %0d", n,
                 bus.pc, bus.id_valid, bus.id_instr, bus.id_pc, bus.id_pc4, bus.id_addr_err, bus.id_range_err, bus.fetch_count,
                 m_pc, m_valid, m_instr, m_id_pc, m_id_pc4, m_aerr, m_rerr, m_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    for (int i = 0; i < 2048; i++) mem[i] = (i < 8) ? 32'h1000_0000 + i : $urandom;
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_range();
    test_misalign();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the imem address and read enable.
- Captures the combinational imem read data into an IF/ID pipeline register.
- Handles stall, redirect (branch/jump/jr) and fetch-error tagging, and feeds the decode stage.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- IMEM_BASE, 32'h0040_0000, byte address mapped to imem word 0.
- IMEM_WORDS, 2048, imem depth in 32-bit words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (hazard from downstream).
- redirect  in  1  load redirect_pc as next PC and squash the current fetch.
- redirect_pc  in  32  branch/jump/jr target byte address.
- imem_a  out  32  byte address to imem, equal to pc - IMEM_BASE (combinational).
- imem_r  out  1  imem read enable (combinational).
- imem_rd  in  32  imem read data, same-cycle combinational.
- pc  out  32  current fetch PC.
- id_valid  out  1  IF/ID holds a live instruction.
- id_instr  out  32  instruction to decode.
- id_pc  out  32  PC of id_instr.
- id_pc4  out  32  id_pc + 4.
- id_addr_err  out  1  fetch PC was misaligned.
- id_range_err  out  1  fetch PC was outside the imem window.
- fetch_count  out  32  number of instructions delivered to IF/ID.

Behaviour:
- Reset is asynchronous and active-high. On assertion: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, id_addr_err=0, id_range_err=0, fetch_count=0.
- Reset release must not glitch any register; the first fetch occurs at the first rising edge after deassertion.
- offset = pc - IMEM_BASE, 32-bit modulo arithmetic.
- in_range = offset[31:2] < IMEM_WORDS.
- imem_a = offset.
- imem_r = !rst && !stall && in_range && pc[1:0]==0.
- Next-PC priority, evaluated on each rising edge:
  1. rst.
  2. redirect: pc <= {redirect_pc[31:2],2'b00}. A misaligned redirect_pc[1:0] is latched in a pending-misalign flag, reported as id_addr_err on the next delivered instruction, then cleared.
  3. stall: pc holds.
  4. Otherwise pc <= pc+4, wrapping at 2^32 with no flag.
- IF/ID update, same priority order:
  - redirect: id_valid<=0 and id_instr<=0 (squash), even if stall is high. Redirect beats stall.
  - stall with no redirect: all id_* hold.
  - Otherwise: id_valid<=1, id_pc<=pc, id_pc4<=pc+4, id_range_err<=!in_range, id_addr_err<=pending-misalign flag.
  - id_instr <= imem_rd when in_range. If out of range, id_instr<=32'h0000_0000 (NOP) and imem_rd is ignored, since it is x when imem_r=0.
- Fetch latency: an instruction at PC p appears on id_instr one clock after pc==p, provided there is no stall or redirect in that cycle. Sustained throughput is 1 instruction/clock.
- fetch_count increments by 1 on every edge where id_valid is loaded to 1, including error-tagged NOPs. It wraps at 2^32.
- Errors do not halt fetch; the downstream exception logic owns the response.
- A single always block for the PC and one for IF/ID is sufficient; no other state.

Test Plan:
- Reset then free-run with imem preloaded with words 0..7 = 32'h1000_0000+i: pc steps 0x00400000, 0x00400004, …; id_instr=32'h1000_0000 one clock after release; fetch_count=8 after 8 clocks.
- Hold stall high for 3 cycles at pc=0x00400008: pc, id_instr and id_pc frozen; imem_r=0; fetch_count unchanged; normal resume at 0x0040000C.
- Redirect to 0x00400040 with stall high in the same cycle: next id_valid=0; pc=0x00400040; the following cycle delivers word 16 with id_pc=0x00400040.
- Redirect to 0x00402000 (word 2048, out of range): imem_r=0; id_instr=0, id_range_err=1, id_valid=1; fetch_count increments.
- Redirect to 0x00400006: pc=0x00400004; the delivered instruction has id_addr_err=1; the next instruction has id_addr_err=0.
- Assert rst asynchronously mid-cycle during a stall: all outputs go to reset values immediately, without waiting for a clk edge; fetch restarts at RESET_PC.
